// File: rtl/mul_cell_sequencer.sv
// mul_cell_sequencer: drives an external DATA_W x NIB_W multiplier cell one
// src2 slice at a time. It shift-accumulates the partial products into the
// low DATA_W bits of src1*src2 and returns the result over a valid/ready
// handshake.
module mul_cell_sequencer #(
  parameter int DATA_W       = 32,
  parameter int NIB_W        = 4,
  parameter int CELL_LATENCY = 1,
  parameter int EARLY_EXIT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              flush,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] cell_src1,
  output logic [NIB_W-1:0]  cell_src2,
  input  logic [DATA_W-1:0] cell_result,
  output logic              cell_aclr
);

  localparam int NIBS = DATA_W / NIB_W;
  localparam int IDXW = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam int DCW  = (CELL_LATENCY > 1) ? $clog2(CELL_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] src1_q, src2_q, acc_q;
  logic [IDXW-1:0]   idx_q, lastIdx_q;
  logic [DCW-1:0]    drainCnt_q;
  logic              tagValid_q [CELL_LATENCY];
  logic [IDXW-1:0]   tagK_q     [CELL_LATENCY];

  logic              accept;
  logic              abort;
  logic              issueFire;
  logic [IDXW-1:0]   highIdx;
  logic [IDXW-1:0]   lastIdxIn;
  logic [DATA_W-1:0] partial;

  assign accept    = (state_q == IDLE) && start && !flush;
  assign abort     = (state_q != IDLE) && flush;
  assign issueFire = (state_q == ISSUE) && !flush;
  assign cell_aclr = reset;

  // Find the highest nonzero src2 slice so early exit can skip the zero slices above it
  always_comb begin
    highIdx = '0;
    for (int i = 0; i < NIBS; i++) begin
      if (src2[i*NIB_W +: NIB_W] != '0) highIdx = IDXW'(i);
    end
    lastIdxIn = (EARLY_EXIT != 0) ? highIdx : IDXW'(NIBS - 1);
  end

  // Align the retiring partial product to its slice position
  always_comb begin
    partial = cell_result << (int'(tagK_q[CELL_LATENCY-1]) * NIB_W);
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush beats start and result_ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = ISSUE;
      ISSUE: if (flush) state_d = IDLE;
             else if (idx_q == lastIdx_q) state_d = DRAIN;
      DRAIN: if (flush) state_d = IDLE;
             else if (drainCnt_q == DCW'(CELL_LATENCY - 1)) state_d = DONE;
      DONE:  if (flush || result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; cell_src2 is zero whenever no slice is being issued
  always_comb begin
    ready        = (state_q == IDLE);
    busy         = (state_q != IDLE);
    result_valid = (state_q == DONE);
    result       = acc_q;
    cell_src1    = src1_q;
    cell_src2    = '0;
    if (state_q == ISSUE) cell_src2 = src2_q[int'(idx_q)*NIB_W +: NIB_W];
  end

  // Operand capture at accept, and the slice index that walks src2 during ISSUE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src1_q    <= '0;
      src2_q    <= '0;
      idx_q     <= '0;
      lastIdx_q <= '0;
    end else if (accept) begin
      src1_q    <= src1;
      src2_q    <= src2;
      idx_q     <= '0;
      lastIdx_q <= lastIdxIn;
    end else if (abort) begin
      idx_q <= '0;
    end else if (state_q == ISSUE) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  // Count the DRAIN cycles spent waiting for the last tag to retire
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                drainCnt_q <= '0;
    else if (state_q == DRAIN && !flush)      drainCnt_q <= drainCnt_q + 1'b1;
    else                                      drainCnt_q <= '0;
  end

  // Carry each issue's valid bit and shift amount alongside the cell latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CELL_LATENCY; i++) begin
        tagValid_q[i] <= 1'b0;
        tagK_q[i]     <= '0;
      end
    end else if (abort) begin
      for (int i = 0; i < CELL_LATENCY; i++) tagValid_q[i] <= 1'b0;
    end else begin
      tagValid_q[0] <= issueFire;
      tagK_q[0]     <= idx_q;
      for (int i = 1; i < CELL_LATENCY; i++) begin
        tagValid_q[i] <= tagValid_q[i-1];
        tagK_q[i]     <= tagK_q[i-1];
      end
    end
  end

  // Accumulate the returned partial products; the sum wraps at DATA_W bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            acc_q <= '0;
    else if (accept || abort)             acc_q <= '0;
    else if (tagValid_q[CELL_LATENCY-1])  acc_q <= acc_q + partial;
  end

endmodule

// File: tb/tb_mul_cell_sequencer.sv
// Directed bench for mul_cell_sequencer. One instance uses early exit and the
// other issues every slice. Each instance talks to its own one-cycle cell model.
module tb_mul_cell_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        resultReady = 1'b0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;

  logic        readyE, busyE, validE, aclrE;
  logic        readyF, busyF, validF, aclrF;
  logic [31:0] resultE, resultF, cellSrc1E, cellSrc1F, cellResE, cellResF;
  logic [3:0]  cellSrc2E, cellSrc2F;

  int vectors = 0;
  int miscompares = 0;
  int latE, latF;

  always #5 clk = ~clk;

  mul_cell_sequencer #(.EARLY_EXIT(1)) dutE (
    .clk(clk), .reset(reset), .start(start), .ready(readyE),
    .src1(src1), .src2(src2), .flush(flush), .busy(busyE),
    .result(resultE), .result_valid(validE), .result_ready(resultReady),
    .cell_src1(cellSrc1E), .cell_src2(cellSrc2E), .cell_result(cellResE),
    .cell_aclr(aclrE)
  );

  mul_cell_sequencer #(.EARLY_EXIT(0)) dutF (
    .clk(clk), .reset(reset), .start(start), .ready(readyF),
    .src1(src1), .src2(src2), .flush(flush), .busy(busyF),
    .result(resultF), .result_valid(validF), .result_ready(resultReady),
    .cell_src1(cellSrc1F), .cell_src2(cellSrc2F), .cell_result(cellResF),
    .cell_aclr(aclrF)
  );

  // Multiplier cell models: one registered 32x4 product each, cleared by aclr
  always_ff @(posedge clk or posedge aclrE) begin
    if (aclrE) cellResE <= '0;
    else       cellResE <= cellSrc1E * {28'd0, cellSrc2E};
  end

  always_ff @(posedge clk or posedge aclrF) begin
    if (aclrF) cellResF <= '0;
    else       cellResF <= cellSrc1F * {28'd0, cellSrc2F};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    src1  = a;
    src2  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Count the edges after accept until each instance raises result_valid, up to a bound
  task automatic measure(output int le, output int lf);
    le = 0;
    lf = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (le == 0 && validE) le = c;
      if (lf == 0 && validF) lf = c;
      if (le != 0 && lf != 0) break;
    end
  endtask

  task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] prod, input int expLatE);
    applyStimulus(a, b);
    measure(latE, latF);
    checkOutput({tag, " resultE"}, resultE, prod);
    checkOutput({tag, " resultF"}, resultF, prod);
    checkOutput({tag, " latE"}, latE, expLatE);
    checkOutput({tag, " latF"}, latF, 9);
    resultReady = 1'b1;
    tick();
    resultReady = 1'b0;
    checkOutput({tag, " readyE after handshake"}, readyE, 1);
    checkOutput({tag, " readyF after handshake"}, readyF, 1);
    checkOutput({tag, " validF after handshake"}, validF, 0);
  endtask

  initial begin
    // Reset state
    #2;
    checkOutput("reset ready", readyE, 1);
    checkOutput("reset busy", busyE, 0);
    checkOutput("reset result", resultE, 0);
    checkOutput("reset valid", validE, 0);
    checkOutput("reset cell_src1", cellSrc1E, 0);
    checkOutput("reset cell_src2", cellSrc2E, 0);
    checkOutput("reset aclr", aclrE, 1);
    #10;
    reset = 1'b0;
    tick();

    // T1: slices 0 and 4 set, early exit stops after slice 4
    runOp("T1", 32'h0001_0001, 32'h0003_0003, 32'h0006_0003, 6);

    // T2: wraparound products
    runOp("T2a", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 9);
    runOp("T2b", 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 2);

    // T3: early exit on small, zero and top-slice multipliers
    runOp("T3a", 32'd7, 32'd5, 32'h0000_0023, 2);
    runOp("T3b", 32'd7, 32'd0, 32'h0000_0000, 2);
    runOp("T3c", 32'd3, 32'h1000_0000, 32'h3000_0000, 9);

    // T4: result held under backpressure, start pulses ignored
    applyStimulus(32'h0000_1234, 32'h0000_0010);
    measure(latE, latF);
    checkOutput("T4 latE", latE, 3);
    checkOutput("T4 resultF", resultF, 32'h0001_2340);
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      src1  = 32'(i + 9);
      src2  = 32'(i + 1);
      tick();
      checkOutput("T4 held resultF", resultF, 32'h0001_2340);
      checkOutput("T4 held resultE", resultE, 32'h0001_2340);
      checkOutput("T4 held validF", validF, 1);
      checkOutput("T4 held readyF", readyF, 0);
    end
    start = 1'b0;
    resultReady = 1'b1;
    tick();
    resultReady = 1'b0;
    checkOutput("T4 ready after release", readyF, 1);
    checkOutput("T4 valid after release", validF, 0);
    checkOutput("T4 busy after release", busyF, 0);

    // T5: flush at idx 3 together with start
    applyStimulus(32'd5, 32'h1111_1111);
    checkOutput("T5 cell_src1 in issue", cellSrc1F, 32'd5);
    checkOutput("T5 cell_src2 in issue", cellSrc2F, 1);
    checkOutput("T5 busy in issue", busyF, 1);
    checkOutput("T5 ready in issue", readyF, 0);
    tick();
    tick();
    tick();
    flush = 1'b1;
    start = 1'b1;
    tick();
    flush = 1'b0;
    start = 1'b0;
    checkOutput("T5 ready after flush", readyF, 1);
    checkOutput("T5 busyE after flush", busyE, 0);
    checkOutput("T5 cell_src2 after flush", cellSrc2F, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      checkOutput("T5 no validF", validF, 0);
      checkOutput("T5 no validE", validE, 0);
    end
    runOp("T5 next", 32'd6, 32'd7, 32'd42, 2);

    // T6: asynchronous reset mid-ISSUE
    applyStimulus(32'hDEAD_BEEF, 32'h1234_5678);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("T6 aclr", aclrF, 1);
    checkOutput("T6 ready", readyF, 1);
    checkOutput("T6 busy", busyF, 0);
    checkOutput("T6 result", resultF, 0);
    checkOutput("T6 valid", validF, 0);
    checkOutput("T6 cell_src1", cellSrc1F, 0);
    checkOutput("T6 cell_src2", cellSrc2F, 0);
    #1;
    reset = 1'b0;
    tick();
    checkOutput("T6 aclr released", aclrF, 0);
    runOp("T6 after", 32'd3, 32'd4, 32'd12, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
